// File: rtl/uart_recv_data_if.sv
// uart_recv_data_if
//   Bundles the byte-receive and APB RX-register signals of uart_recv_data.
//   master : the side that drives uart_done/uart_data/apb_ren/ovr_clr
//            (UART receiver + APB slave) and observes the FIFO status.
//   slave  : the FIFO block itself.
//   Signals:
//     uart_done  receiver byte-complete level (rising edge = new byte)
//     uart_data  received byte, valid when uart_done rises
//     apb_ren    APB RX-data read strobe (rising edge = one pop)
//     ovr_clr    single-cycle overrun clear pulse
//     apb_rdata  last popped byte
//     rx_avail   FIFO non-empty
//     rx_full    FIFO holds DEPTH bytes
//     rx_count   bytes currently held (AW+1 bits)
//     overrun    sticky dropped-byte flag
interface uart_recv_data_if #(
  parameter int AW = 4
);
  logic          uart_done;
  logic [7:0]    uart_data;
  logic          apb_ren;
  logic          ovr_clr;
  logic [7:0]    apb_rdata;
  logic          rx_avail;
  logic          rx_full;
  logic [AW:0]   rx_count;
  logic          overrun;

  modport master (
    output uart_done, uart_data, apb_ren, ovr_clr,
    input  apb_rdata, rx_avail, rx_full, rx_count, overrun
  );

  modport slave (
    input  uart_done, uart_data, apb_ren, ovr_clr,
    output apb_rdata, rx_avail, rx_full, rx_count, overrun
  );
endinterface

// File: rtl/uart_recv_data.sv
// uart_recv_data
//   Receive-side byte buffer between the UART RX deserializer and the APB
//   RX data/status registers. Rising edges of uart_done push uart_data into
//   a DEPTH-byte synchronous FIFO; rising edges of apb_ren pop one byte into
//   the registered apb_rdata. Overflowing pushes set a sticky overrun flag.
//   Ports:
//     sys_clk    system clock, rising edge
//     sys_rst_n  asynchronous active-low reset
//     bus        uart_recv_data_if.slave (done/data in, read strobe,
//                overrun clear, read data and status out)
//   Parameters: DEPTH (power of two, >= 2), AW = log2(DEPTH).
module uart_recv_data #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  uart_recv_data_if.slave    bus
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  // Edge-detect delay lines
  logic        done_d0_reg;
  logic        done_d1_reg;
  logic [7:0]  data_d0_reg;
  logic        ren_d0_reg;
  logic        ren_d1_reg;

  // FIFO state
  logic [7:0]  mem [DEPTH];
  logic [AW-1:0] wptr_reg;
  logic [AW-1:0] rptr_reg;
  logic [AW:0]   count_reg;
  logic [AW:0]   count_next;
  logic [7:0]    rdata_reg;
  logic          overrun_reg;

  logic push;
  logic pop;
  logic empty;
  logic full;
  logic push_ok;
  logic pop_ok;
  logic drop;

  assign push  = done_d0_reg & ~done_d1_reg;
  assign pop   = ren_d0_reg & ~ren_d1_reg;
  assign empty = (count_reg == '0);
  assign full  = (count_reg == FULL_CNT);

  // When full, a simultaneous pop frees the slot first, so the push lands.
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop);
  assign drop    = push & full & ~pop;

  always_comb begin
    count_next = count_reg;
    case ({push_ok, pop_ok})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      done_d0_reg <= 1'b0;
      done_d1_reg <= 1'b0;
      data_d0_reg <= 8'h00;
      ren_d0_reg  <= 1'b0;
      ren_d1_reg  <= 1'b0;
    end else begin
      done_d0_reg <= bus.uart_done;
      done_d1_reg <= done_d0_reg;
      data_d0_reg <= bus.uart_data;
      ren_d0_reg  <= bus.apb_ren;
      ren_d1_reg  <= ren_d0_reg;
    end
  end

  // Storage has no reset so it can map onto block/distributed RAM.
  always_ff @(posedge sys_clk) begin
    if (push_ok) begin
      mem[wptr_reg] <= data_d0_reg;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wptr_reg    <= '0;
      rptr_reg    <= '0;
      count_reg   <= '0;
      rdata_reg   <= 8'h00;
      overrun_reg <= 1'b0;
    end else begin
      count_reg <= count_next;
      if (push_ok) begin
        wptr_reg <= wptr_reg + 1'b1;
      end
      if (pop) begin
        // Reading while the same slot is written returns the old byte,
        // which is the oldest entry when the FIFO is full.
        if (pop_ok) begin
          rdata_reg <= mem[rptr_reg];
          rptr_reg  <= rptr_reg + 1'b1;
        end else begin
          rdata_reg <= 8'h00;
        end
      end
      // Set has priority over clear.
      if (drop) begin
        overrun_reg <= 1'b1;
      end else if (bus.ovr_clr) begin
        overrun_reg <= 1'b0;
      end
    end
  end

  assign bus.apb_rdata = rdata_reg;
  assign bus.rx_count  = count_reg;
  assign bus.rx_avail  = ~empty;
  assign bus.rx_full   = full;
  assign bus.overrun   = overrun_reg;

endmodule
